// File: rtl/divider_ctrl.sv
// Run-time programmable clock-divider controller: square-wave OUT, TICK per period,
// glitch-free ratio swaps at period boundaries. Define DIVIDER_CTRL_AUTOSTART_EN to leave reset already running.
module divider_ctrl #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 10
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DIV_IN,
   input  logic             LOAD,
   input  logic             START,
   input  logic             STOP,
   output logic             OUT,
   output logic             TICK,
   output logic             BUSY,
   output logic             ACK,
   output logic             ERR
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOPPING
   } state_e;

   localparam logic [WIDTH-1:0] DEFAULT_N = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(2);

`ifdef DIVIDER_CTRL_AUTOSTART_EN
   localparam state_e RESET_STATE = ST_RUN;
`else
   localparam state_e RESET_STATE = ST_IDLE;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] n_act_q, n_act_d;
   logic [WIDTH-1:0] n_pend_q, n_pend_d;
   logic             pend_q, pend_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;

   logic busy;
   logic boundary;
   logic load_ok;

   assign busy     = (state_q != ST_IDLE);
   assign boundary = busy && (cnt_q == n_act_q - ONE);
   assign load_ok  = LOAD && (DIV_IN >= MIN_DIV);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      n_act_d  = n_act_q;
      n_pend_d = n_pend_q;
      pend_d   = pend_q;
      ack_d    = 1'b0;
      err_d    = LOAD && !load_ok;

      if (busy) begin
         cnt_d = boundary ? '0 : cnt_q + ONE;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (START && !STOP) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (STOP) begin
               state_d = ST_STOPPING;
            end
         end
         ST_STOPPING: begin
            // A START alone cancels the stop without touching the counter.
            if (START && !STOP) begin
               state_d = ST_RUN;
            end else if (boundary) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Ratio swaps only where a period has just ended, so no runt pulse appears.
      if (pend_q && (!busy || boundary)) begin
         n_act_d = n_pend_q;
         pend_d  = 1'b0;
         ack_d   = 1'b1;
      end

      if (load_ok) begin
         n_pend_d = DIV_IN;
         pend_d   = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= RESET_STATE;
         cnt_q    <= '0;
         n_act_q  <= DEFAULT_N;
         n_pend_q <= DEFAULT_N;
         pend_q   <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         n_act_q  <= n_act_d;
         n_pend_q <= n_pend_d;
         pend_q   <= pend_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
      end
   end

   assign OUT  = busy && (cnt_q < (n_act_q >> 1));
   assign TICK = boundary;
   assign BUSY = busy;
   assign ACK  = ack_q;
   assign ERR  = err_q;

endmodule
